// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Issue-side controller for the 32-bit ArithmeticLogicUnit. One request is
// accepted at a time over ReqValid/ReqReady. The sequencer drives the ALU
// operands and function select, pulses WF for a flag-setting op, then
// captures ALUOut and the ALU's registered flags. It also evaluates the
// request's condition code on those flags. A predicated request whose
// condition fails on the current flags is skipped without touching the ALU.
// The result is returned over RspValid/RspReady.
//
// Ports
//   Clock, Reset             rising-edge clock, synchronous active-high reset
//   ReqValid / ReqReady      request handshake (ReqReady high only when idle)
//   ReqFunSel, ReqA, ReqB    ALU op code and operands, latched on accept
//   ReqSetFlags              1 = this op updates the ALU flag register
//   ReqCond, ReqPred         condition code; predicate enables skipping
//   A, B, FunSel, WF         drive to the ALU
//   ALUOut, FlagsIn          from the ALU; flags ordered {Z,C,N,O}
//   RspValid / RspReady      response handshake
//   RspResult, RspFlags      captured ALUOut (0 when skipped) and flags
//   RspCondTrue, RspExec     condition on RspFlags; 1 = executed, 0 = skipped
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int DATA_W = 32,
   parameter int CC_W   = 3
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic [4:0]        ReqFunSel,
   input  logic [DATA_W-1:0] ReqA,
   input  logic [DATA_W-1:0] ReqB,
   input  logic              ReqSetFlags,
   input  logic [CC_W-1:0]   ReqCond,
   input  logic              ReqPred,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [4:0]        FunSel,
   output logic              WF,
   input  logic [DATA_W-1:0] ALUOut,
   input  logic [3:0]        FlagsIn,
   output logic              RspValid,
   input  logic              RspReady,
   output logic [DATA_W-1:0] RspResult,
   output logic [3:0]        RspFlags,
   output logic              RspCondTrue,
   output logic              RspExec
);

   typedef enum logic [1:0] {IDLE, EXEC, FLAG, RESP} state_t;

   state_t              state_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic [4:0]          funsel_q;
   logic [CC_W-1:0]     cond_q;
   logic                wf_q;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_result_q;
   logic [3:0]          rsp_flags_q;
   logic                rsp_cond_q;
   logic                rsp_exec_q;
   logic                req_cond_d;

   // Condition code evaluated on flags ordered {Z,C,N,O}.
   function automatic logic cond_eval(input logic [CC_W-1:0] cc, input logic [3:0] fl);
      logic z, c, n, o;
      z = fl[3];
      c = fl[2];
      n = fl[1];
      o = fl[0];
      case (cc)
         3'b000:  return 1'b1;      // AL
         3'b001:  return z;         // EQ
         3'b010:  return !z;        // NE
         3'b011:  return c;         // CS
         3'b100:  return !c;        // CC
         3'b101:  return n;         // MI
         3'b110:  return o;         // VS
         default: return (n == o);  // GE
      endcase
   endfunction

   // Predicate test uses the flags as they stand at the accept edge.
   assign req_cond_d = cond_eval(ReqCond, FlagsIn);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         funsel_q     <= '0;
         cond_q       <= '0;
         wf_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_cond_q   <= 1'b0;
         rsp_exec_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ReqValid) begin
                  a_q      <= ReqA;
                  b_q      <= ReqB;
                  funsel_q <= ReqFunSel;
                  cond_q   <= ReqCond;
                  if (ReqPred && !req_cond_d) begin
                     // Skipped op: response fields are final now, but
                     // RspValid rises one cycle later (first RESP cycle).
                     rsp_result_q <= '0;
                     rsp_flags_q  <= FlagsIn;
                     rsp_cond_q   <= 1'b0;
                     rsp_exec_q   <= 1'b0;
                     state_q      <= RESP;
                  end else begin
                     // WF is the latched SetFlags, live only during EXEC.
                     wf_q    <= ReqSetFlags;
                     state_q <= EXEC;
                  end
               end
            end
            EXEC: begin
               // ALUOut is combinational on the held operands; the ALU
               // commits its flags on this same edge.
               rsp_result_q <= ALUOut;
               wf_q         <= 1'b0;
               state_q      <= FLAG;
            end
            FLAG: begin
               rsp_flags_q <= FlagsIn;
               rsp_cond_q  <= cond_eval(cond_q, FlagsIn);
               rsp_exec_q  <= 1'b1;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (!rsp_valid_q) begin
                  rsp_valid_q <= 1'b1;
               end else if (RspReady) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ReqReady    = (state_q == IDLE);
   assign A           = a_q;
   assign B           = b_q;
   assign FunSel      = funsel_q;
   assign WF          = wf_q;
   assign RspValid    = rsp_valid_q;
   assign RspResult   = rsp_result_q;
   assign RspFlags    = rsp_flags_q;
   assign RspCondTrue = rsp_cond_q;
   assign RspExec     = rsp_exec_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for alu_op_sequencer. Contains a behavioural ALU (combinational
// result, flag register written when WF is high, no reset) and a
// transaction-level reference model of what each request should return.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        ReqValid;
   logic        ReqReady;
   logic [4:0]  ReqFunSel;
   logic [31:0] ReqA;
   logic [31:0] ReqB;
   logic        ReqSetFlags;
   logic [2:0]  ReqCond;
   logic        ReqPred;
   logic [31:0] A;
   logic [31:0] B;
   logic [4:0]  FunSel;
   logic        WF;
   logic [31:0] ALUOut;
   logic [3:0]  FlagsIn;
   logic        RspValid;
   logic        RspReady;
   logic [31:0] RspResult;
   logic [3:0]  RspFlags;
   logic        RspCondTrue;
   logic        RspExec;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference-model state and the expectation for the current transaction.
   logic [3:0]  model_flags = 4'b0000;
   logic [31:0] exp_res;
   logic [3:0]  exp_flags;
   logic        exp_ct;
   logic        exp_ex;

   always #5 Clock = ~Clock;

   alu_op_sequencer #(.DATA_W(32), .CC_W(3)) dut (
      .Clock(Clock), .Reset(Reset),
      .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqFunSel(ReqFunSel), .ReqA(ReqA), .ReqB(ReqB),
      .ReqSetFlags(ReqSetFlags), .ReqCond(ReqCond), .ReqPred(ReqPred),
      .A(A), .B(B), .FunSel(FunSel), .WF(WF),
      .ALUOut(ALUOut), .FlagsIn(FlagsIn),
      .RspValid(RspValid), .RspReady(RspReady),
      .RspResult(RspResult), .RspFlags(RspFlags),
      .RspCondTrue(RspCondTrue), .RspExec(RspExec)
   );

   // Behavioural ALU: returns {Z,C,N,O, result}. FunSel[4]=1 selects 32-bit,
   // otherwise the op works on the low 16 bits. Subtract reports C as borrow.
   function automatic logic [35:0] alu_calc(input logic [4:0] fs, input logic [31:0] a,
                                            input logic [31:0] b, input logic [3:0] fl);
      int          w;
      logic [31:0] msk, am, bm, r;
      logic [32:0] wide;
      logic        z, c, n, o;
      w    = fs[4] ? 32 : 16;
      msk  = fs[4] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      am   = a & msk;
      bm   = b & msk;
      c    = fl[2];
      o    = fl[0];
      r    = '0;
      wide = '0;
      case (fs[3:0])
         4'h0: r = am;
         4'h1: r = bm;
         4'h2: r = ~am;
         4'h3: r = ~bm;
         4'h4, 4'h5: begin
            wide = {1'b0, am} + {1'b0, bm} + {32'b0, (fs[3:0] == 4'h5) & fl[2]};
            r    = wide[31:0] & msk;
            c    = wide[w];
            o    = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
         end
         4'h6: begin
            r = (am - bm) & msk;
            c = (am < bm);
            o = (am[w-1] != bm[w-1]) && (r[w-1] != am[w-1]);
         end
         4'h7: r = am & bm;
         4'h8: r = am | bm;
         4'h9: r = am ^ bm;
         4'hA: r = ~(am & bm);
         4'hB: begin c = am[w-1]; r = am << 1; end
         4'hC: begin c = am[0];   r = am >> 1; end
         4'hD: begin c = am[0];   r = (am >> 1) | ({31'b0, am[w-1]} << (w-1)); end
         4'hE: begin c = am[w-1]; r = (am << 1) | {31'b0, am[w-1]}; end
         default: begin c = am[0]; r = (am >> 1) | ({31'b0, am[0]} << (w-1)); end
      endcase
      r = r & msk;
      z = (r == 32'h0);
      n = r[w-1];
      return {z, c, n, o, r};
   endfunction

   function automatic logic cond_ok(input logic [2:0] cc, input logic [3:0] f);
      case (cc)
         3'd0:    return 1'b1;
         3'd1:    return f[3];
         3'd2:    return !f[3];
         3'd3:    return f[2];
         3'd4:    return !f[2];
         3'd5:    return f[1];
         3'd6:    return f[0];
         default: return f[1] == f[0];
      endcase
   endfunction

   // ALU environment: flag register has no reset.
   logic [3:0]  alu_flags = 4'b0000;
   logic [35:0] alu_comb;
   assign alu_comb = alu_calc(FunSel, A, B, alu_flags);
   assign ALUOut   = alu_comb[31:0];
   assign FlagsIn  = alu_flags;
   always @(posedge Clock) if (WF) alu_flags <= alu_comb[35:32];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Issue one request (called at a falling edge), follow it to its response
   // and check it. Leaves the response pending.
   task automatic send(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                       input logic sf, input logic [2:0] cc, input logic pd);
      logic [35:0] r;
      int          lat, wfc;
      exp_ex = !pd || cond_ok(cc, model_flags);
      if (exp_ex) begin
         r       = alu_calc(fs, a, b, model_flags);
         exp_res = r[31:0];
         if (sf) model_flags = r[35:32];
         exp_flags = model_flags;
         exp_ct    = cond_ok(cc, model_flags);
      end else begin
         exp_res   = 32'h0;
         exp_flags = model_flags;
         exp_ct    = 1'b0;
      end
      ReqFunSel = fs; ReqA = a; ReqB = b; ReqSetFlags = sf; ReqCond = cc; ReqPred = pd;
      ReqValid  = 1'b1;
      chk("req_ready_idle", 32'(ReqReady), 32'd1);
      @(posedge Clock);
      @(negedge Clock);
      ReqValid = 1'b0;
      lat = 0;
      wfc = 0;
      while (RspValid !== 1'b1 && lat < 8) begin
         if (WF === 1'b1) wfc++;
         chk("a_hold", A, a);
         chk("b_hold", B, b);
         chk("funsel_hold", 32'(FunSel), 32'(fs));
         @(negedge Clock);
         lat++;
      end
      chk("latency", 32'(lat), exp_ex ? 32'd2 : 32'd1);
      chk("wf_cycles", 32'(wfc), (exp_ex && sf) ? 32'd1 : 32'd0);
      chk("wf_resp", 32'(WF), 32'd0);
      chk("rsp_result", RspResult, exp_res);
      chk("rsp_flags", 32'(RspFlags), 32'(exp_flags));
      chk("rsp_cond", 32'(RspCondTrue), 32'(exp_ct));
      chk("rsp_exec", 32'(RspExec), 32'(exp_ex));
      chk("req_ready_busy", 32'(ReqReady), 32'd0);
   endtask

   // Hold the response for 'delay' cycles, then consume it.
   task automatic release_rsp(input int delay);
      for (int i = 0; i < delay; i++) begin
         @(negedge Clock);
         chk("hold_valid", 32'(RspValid), 32'd1);
         chk("hold_result", RspResult, exp_res);
         chk("hold_flags", 32'(RspFlags), 32'(exp_flags));
         chk("hold_ready_low", 32'(ReqReady), 32'd0);
      end
      RspReady = 1'b1;
      @(negedge Clock);
      RspReady = 1'b0;
      chk("rsp_done", 32'(RspValid), 32'd0);
      chk("back_idle", 32'(ReqReady), 32'd1);
   endtask

   initial begin
      logic [35:0] r6;
      int          seen;
      Reset = 1'b1; ReqValid = 1'b0; RspReady = 1'b0;
      ReqFunSel = '0; ReqA = '0; ReqB = '0; ReqSetFlags = 1'b0; ReqCond = '0; ReqPred = 1'b0;
      repeat (3) @(negedge Clock);
      Reset = 1'b0;

      // Reset state
      chk("rst_req_ready", 32'(ReqReady), 32'd1);
      chk("rst_rsp_valid", 32'(RspValid), 32'd0);
      chk("rst_wf", 32'(WF), 32'd0);
      chk("rst_a", A, 32'h0);
      chk("rst_b", B, 32'h0);
      chk("rst_funsel", 32'(FunSel), 32'd0);
      chk("rst_result", RspResult, 32'h0);
      chk("rst_flags", 32'(RspFlags), 32'd0);
      chk("rst_exec", 32'(RspExec), 32'd0);
      chk("rst_cond", 32'(RspCondTrue), 32'd0);

      // 32-bit add wrapping to zero: Z and C set
      send(5'b10100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b001, 1'b0);
      chk("t1_result", RspResult, 32'h0);
      chk("t1_flags", 32'(RspFlags), 32'b1100);
      chk("t1_cond", 32'(RspCondTrue), 32'd1);
      release_rsp(0);

      // 16-bit subtract going negative; GE fails since N != O
      send(5'b00110, 32'h0000_0003, 32'h0000_0005, 1'b1, 3'b111, 1'b0);
      chk("t2_result", RspResult, 32'h0000_FFFE);
      chk("t2_flags", 32'(RspFlags), 32'b0110);
      chk("t2_cond", 32'(RspCondTrue), 32'd0);
      release_rsp(0);

      // Predicated EQ with Z clear: skipped
      send(5'b10000, 32'h0000_1234, 32'h0, 1'b1, 3'b001, 1'b1);
      chk("t3_exec", 32'(RspExec), 32'd0);
      chk("t3_result", RspResult, 32'h0);
      chk("t3_flags", 32'(RspFlags), 32'b0110);
      release_rsp(0);

      // SetFlags=0: flags unchanged
      send(5'b11000, 32'h0000_00F0, 32'h0000_000F, 1'b0, 3'b000, 1'b0);
      chk("t4_result", RspResult, 32'h0000_00FF);
      chk("t4_flags", 32'(RspFlags), 32'b0110);
      release_rsp(0);

      // Backpressure with a second request pending
      send(5'b10100, 32'h10, 32'h20, 1'b1, 3'b000, 1'b0);
      ReqFunSel = 5'b10110; ReqA = 32'h100; ReqB = 32'h1; ReqSetFlags = 1'b1;
      ReqCond = 3'b010; ReqPred = 1'b0; ReqValid = 1'b1;
      release_rsp(5);
      send(5'b10110, 32'h100, 32'h1, 1'b1, 3'b010, 1'b0);
      chk("t5_result", RspResult, 32'h0000_00FF);
      release_rsp(0);

      // Reset during EXEC drops the op; the ALU still commits its flags
      ReqFunSel = 5'b10100; ReqA = 32'h7FFF_FFFF; ReqB = 32'h1; ReqSetFlags = 1'b1;
      ReqCond = 3'b000; ReqPred = 1'b0; ReqValid = 1'b1;
      r6 = alu_calc(5'b10100, 32'h7FFF_FFFF, 32'h1, model_flags);
      @(posedge Clock);
      @(negedge Clock);
      ReqValid = 1'b0;
      chk("t6_wf_exec", 32'(WF), 32'd1);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      model_flags = r6[35:32];
      chk("t6_wf", 32'(WF), 32'd0);
      chk("t6_rsp_valid", 32'(RspValid), 32'd0);
      chk("t6_req_ready", 32'(ReqReady), 32'd1);
      chk("t6_a", A, 32'h0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clock);
         if (RspValid !== 1'b0) seen++;
      end
      chk("t6_no_rsp", 32'(seen), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         send(5'($urandom_range(0, 31)), $urandom, $urandom, 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         release_rsp(int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
